reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, number of station lines; fixed at 8 by the 3-bit tag.
REQ-002 SHALL have ports (clock and reset first):
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  issue request this cycle
- issue_ready  out  1  at least one FREE line exists
- issue_tag  out  3  lowest-index FREE line, the line that receives the next issue
- issue_op  in  4  0000 add, 0001 sub, 0010 mul, 0011 div
- issue_dest  in  4  destination register
- issue_vj, issue_vk  in  16 each  operand values
- issue_qj_busy, issue_qk_busy  in  1 each  operand still pending
- issue_qj, issue_qk  in  3 each  producer tag of each pending operand
- fu_request  in  1  functional unit accepts an instruction
- fu_run  out  1  functional unit enable
- fu_instruction  out  43  {tag[42:40], op[39:36], dest[35:32], Vj[31:16], Vk[15:0]}
- fu_done  in  1  fu_solution valid
- fu_solution  in  23  {dest[22:19], tag[18:16], value[15:0]}
- cdb_valid  out  1  result broadcast strobe
- cdb_reg  out  4  broadcast destination register
- cdb_tag  out  3  broadcast line
- cdb_value  out  16  broadcast value
- occupancy  out  4  count of non-FREE lines, 0..8

Function
REQ-003 SHALL give each line a state: FREE, WAIT (an operand is pending), READY (both operands valid) or EXEC (dispatched).
REQ-004 SHALL, when issue_valid and issue_ready are both high at an edge, load line issue_tag and enter WAIT if either busy flag is set, otherwise READY.
REQ-005 SHALL ignore issue_valid while issue_ready is low, with no state change.
REQ-006 SHALL define a result event as fu_done=1 with fu_solution tag naming an EXEC line; fu_done for any non-EXEC line SHALL be ignored entirely.
REQ-007 SHALL, on a result event, capture the value into every WAIT operand whose Q tag matches, clear its busy flag, and move the line to READY once both operands are valid.
REQ-008 SHALL bypass: an operand issued in the same cycle as a result event with a matching tag is captured as valid.
REQ-009 SHALL return the producing line to FREE on its result event; issue_ready reflects the freed line from the next cycle only.
REQ-010 SHALL, at each edge with fu_request=1, register the lowest-index READY line into fu_instruction and mark it EXEC; at most one dispatch per cycle.
REQ-011 SHALL drive a bubble (op 4'b1111, other fields 0) when no line is READY or fu_request=0.
REQ-012 SHALL hold fu_run=1 at all times after reset so the unit keeps draining results.
REQ-013 SHALL register cdb_* from each result event, one cycle later; cdb_valid pulses for exactly one cycle per event.
REQ-014 latency: an operand-complete issue at edge k SHALL appear on fu_instruction after edge k+1 at the earliest.
REQ-015 SHALL update occupancy with every issue and free in the same cycle; a simultaneous issue and free leaves it unchanged.

Reset
REQ-016 SHALL, while reset_n=0 (including mid-operation), force all lines to FREE, fu_instruction to bubble, fu_run=0, cdb_valid=0, cdb_reg/tag/value=0, occupancy=0, issue_tag=0 and issue_ready=1 after release.

Structure
REQ-017 SHALL take opcodes, BUBBLE_OP, field widths, line-state enum and the fu_instruction/fu_solution field positions from the shared package tomasulo_pkg.
REQ-018 SHALL use sub-module rs_entry (one line's state, operands, tags and wakeup logic), instantiated ENTRIES times; selection and the CDB register stay in the top level.

Verification
REQ-019 Issue add, dest 5, Vj=3, Vk=4, no busy flags -> line 0; after one more edge fu_instruction = {0,0000,5,3,4}; fu_done with {5,0,7} -> cdb {reg 5, tag 0, value 7} one cycle later; line 0 FREE.
REQ-020 Issue mul on line 1 with qj_busy, qj=0, Vk=2; line 0 result 7 -> line 1 READY with Vj=7 and dispatches {1,0010,d,7,2}.
REQ-021 Issue 8 lines -> issue_ready=0 and occupancy=8; a 9th issue is ignored; one result frees that line, and issue_ready=1 on the next cycle.
REQ-022 Same-cycle issue with qk=2 and result tag 2, value 9 -> the operand is captured as 9; the line dispatches without waiting.
REQ-023 Hold fu_request=0 with 3 READY lines -> bubbles only; raise it -> lines 0, 1, 2 are dispatched in that order.
REQ-024 Assert reset_n=0 while lines are in WAIT and EXEC -> all outputs take their reset values immediately; a later fu_done for a stale tag produces no cdb_valid.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo types: field widths, opcodes, line states and the
// fu_instruction / fu_solution layouts used by the reservation station.
package tomasulo_pkg;
    localparam int TAG_W   = 3;
    localparam int OP_W    = 4;
    localparam int REG_W   = 4;
    localparam int VAL_W   = 16;
    localparam int INSTR_W = TAG_W + OP_W + REG_W + 2 * VAL_W;
    localparam int SOL_W   = REG_W + TAG_W + VAL_W;

    localparam logic [OP_W-1:0] OP_ADD    = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB    = 4'b0001;
    localparam logic [OP_W-1:0] OP_MUL    = 4'b0010;
    localparam logic [OP_W-1:0] OP_DIV    = 4'b0011;
    localparam logic [OP_W-1:0] BUBBLE_OP = 4'b1111;

    typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_EXEC} line_state_t;

    // Packed order fixes the bus layout: {tag, op, dest, Vj, Vk}.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] dest;
        logic [VAL_W-1:0] vj;
        logic [VAL_W-1:0] vk;
    } fu_instr_t;

    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic [TAG_W-1:0] tag;
        logic [VAL_W-1:0] value;
    } fu_sol_t;

    localparam fu_instr_t BUBBLE_INSTR = '{tag: '0, op: BUBBLE_OP, dest: '0, vj: '0, vk: '0};
endpackage

// File: rtl/reservation_station_if.sv
// Issue, functional-unit and CDB signals of the reservation station.
interface reservation_station_if;
    import tomasulo_pkg::*;

    logic               issue_valid;
    logic               issue_ready;
    logic [TAG_W-1:0]   issue_tag;
    logic [OP_W-1:0]    issue_op;
    logic [REG_W-1:0]   issue_dest;
    logic [VAL_W-1:0]   issue_vj;
    logic [VAL_W-1:0]   issue_vk;
    logic               issue_qj_busy;
    logic               issue_qk_busy;
    logic [TAG_W-1:0]   issue_qj;
    logic [TAG_W-1:0]   issue_qk;
    logic               fu_request;
    logic               fu_run;
    logic [INSTR_W-1:0] fu_instruction;
    logic               fu_done;
    logic [SOL_W-1:0]   fu_solution;
    logic               cdb_valid;
    logic [REG_W-1:0]   cdb_reg;
    logic [TAG_W-1:0]   cdb_tag;
    logic [VAL_W-1:0]   cdb_value;
    logic [3:0]         occupancy;

    modport slave (
        input  issue_valid, issue_op, issue_dest, issue_vj, issue_vk,
               issue_qj_busy, issue_qk_busy, issue_qj, issue_qk,
               fu_request, fu_done, fu_solution,
        output issue_ready, issue_tag, fu_run, fu_instruction,
               cdb_valid, cdb_reg, cdb_tag, cdb_value, occupancy
    );

    modport master (
        output issue_valid, issue_op, issue_dest, issue_vj, issue_vk,
               issue_qj_busy, issue_qk_busy, issue_qj, issue_qk,
               fu_request, fu_done, fu_solution,
        input  issue_ready, issue_tag, fu_run, fu_instruction,
               cdb_valid, cdb_reg, cdb_tag, cdb_value, occupancy
    );
endinterface

// File: rtl/rs_entry.sv
// One reservation-station line: state machine, operand values, producer tags
// and CDB wakeup, including same-cycle bypass of a result into a new issue.
module rs_entry
    import tomasulo_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             issue_en,
    input  logic [OP_W-1:0]  issue_op,
    input  logic [REG_W-1:0] issue_dest,
    input  logic [VAL_W-1:0] issue_vj,
    input  logic [VAL_W-1:0] issue_vk,
    input  logic             issue_qj_busy,
    input  logic             issue_qk_busy,
    input  logic [TAG_W-1:0] issue_qj,
    input  logic [TAG_W-1:0] issue_qk,
    input  logic             dispatch_en,
    input  logic             free_en,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic [VAL_W-1:0] res_value,
    output logic             free,
    output logic             ready,
    output logic             exec,
    output logic [OP_W-1:0]  op,
    output logic [REG_W-1:0] dest,
    output logic [VAL_W-1:0] vj,
    output logic [VAL_W-1:0] vk
);
    line_state_t      state, state_d;
    logic             qj_busy, qk_busy;
    logic [TAG_W-1:0] qj, qk;
    logic             byp_j, byp_k, hit_j, hit_k;

    assign byp_j = issue_qj_busy && res_valid && (issue_qj == res_tag);
    assign byp_k = issue_qk_busy && res_valid && (issue_qk == res_tag);
    assign hit_j = (state == ST_WAIT) && qj_busy && res_valid && (qj == res_tag);
    assign hit_k = (state == ST_WAIT) && qk_busy && res_valid && (qk == res_tag);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_FREE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_FREE:  if (issue_en)
                          state_d = ((issue_qj_busy && !byp_j) || (issue_qk_busy && !byp_k))
                                    ? ST_WAIT : ST_READY;
            ST_WAIT:  if ((!qj_busy || hit_j) && (!qk_busy || hit_k)) state_d = ST_READY;
            ST_READY: if (dispatch_en) state_d = ST_EXEC;
            ST_EXEC:  if (free_en) state_d = ST_FREE;
            default:  state_d = ST_FREE;
        endcase
    end

    always_comb begin
        free  = (state == ST_FREE);
        ready = (state == ST_READY);
        exec  = (state == ST_EXEC);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op <= '0; dest <= '0; vj <= '0; vk <= '0;
            qj_busy <= 1'b0; qk_busy <= 1'b0; qj <= '0; qk <= '0;
        end else if (issue_en) begin
            op      <= issue_op;
            dest    <= issue_dest;
            vj      <= byp_j ? res_value : issue_vj;
            vk      <= byp_k ? res_value : issue_vk;
            qj_busy <= issue_qj_busy && !byp_j;
            qk_busy <= issue_qk_busy && !byp_k;
            qj      <= issue_qj;
            qk      <= issue_qk;
        end else begin
            if (hit_j) begin vj <= res_value; qj_busy <= 1'b0; end
            if (hit_k) begin vk <= res_value; qk_busy <= 1'b0; end
        end
    end
endmodule

// File: rtl/reservation_station.sv
// Reservation station: ENTRIES lines, lowest-index issue and dispatch
// selection, result-event gating and the registered CDB broadcast.
module reservation_station
    import tomasulo_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input logic                  clock,
    input logic                  reset_n,
    reservation_station_if.slave bus
);
    logic [ENTRIES-1:0]            line_free, line_ready, line_exec;
    logic [ENTRIES-1:0]            issue_en, dispatch_en, free_en;
    logic [ENTRIES-1:0][OP_W-1:0]  line_op;
    logic [ENTRIES-1:0][REG_W-1:0] line_dest;
    logic [ENTRIES-1:0][VAL_W-1:0] line_vj, line_vk;
    logic [TAG_W-1:0]              free_idx, ready_idx;
    logic                          issue_fire, dispatch_fire, res_valid;
    fu_sol_t                       sol;
    fu_instr_t                     instr_q;
    logic                          run_q, cdb_valid_q;
    logic [REG_W-1:0]              cdb_reg_q;
    logic [TAG_W-1:0]              cdb_tag_q;
    logic [VAL_W-1:0]              cdb_value_q;
    logic [3:0]                    occ_q;

    assign sol = fu_sol_t'(bus.fu_solution);
    // A completion only counts when it names a line that is actually executing.
    assign res_valid     = bus.fu_done && line_exec[sol.tag];
    assign issue_fire    = bus.issue_valid && (|line_free);
    assign dispatch_fire = bus.fu_request && (|line_ready);

    always_comb begin
        free_idx  = '0;
        ready_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (line_free[i])  free_idx  = TAG_W'(i);
            if (line_ready[i]) ready_idx = TAG_W'(i);
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_line
        assign issue_en[g]    = issue_fire && (free_idx == TAG_W'(g));
        assign dispatch_en[g] = dispatch_fire && (ready_idx == TAG_W'(g));
        assign free_en[g]     = res_valid && (sol.tag == TAG_W'(g));

        rs_entry u_entry (
            .clock         (clock),
            .reset_n       (reset_n),
            .issue_en      (issue_en[g]),
            .issue_op      (bus.issue_op),
            .issue_dest    (bus.issue_dest),
            .issue_vj      (bus.issue_vj),
            .issue_vk      (bus.issue_vk),
            .issue_qj_busy (bus.issue_qj_busy),
            .issue_qk_busy (bus.issue_qk_busy),
            .issue_qj      (bus.issue_qj),
            .issue_qk      (bus.issue_qk),
            .dispatch_en   (dispatch_en[g]),
            .free_en       (free_en[g]),
            .res_valid     (res_valid),
            .res_tag       (sol.tag),
            .res_value     (sol.value),
            .free          (line_free[g]),
            .ready         (line_ready[g]),
            .exec          (line_exec[g]),
            .op            (line_op[g]),
            .dest          (line_dest[g]),
            .vj            (line_vj[g]),
            .vk            (line_vk[g])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_q     <= BUBBLE_INSTR;
            run_q       <= 1'b0;
            cdb_valid_q <= 1'b0;
            cdb_reg_q   <= '0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            occ_q       <= '0;
        end else begin
            run_q       <= 1'b1;
            instr_q     <= dispatch_fire
                           ? '{tag: ready_idx, op: line_op[ready_idx], dest: line_dest[ready_idx],
                               vj: line_vj[ready_idx], vk: line_vk[ready_idx]}
                           : BUBBLE_INSTR;
            cdb_valid_q <= res_valid;
            if (res_valid) begin
                cdb_reg_q   <= sol.dest;
                cdb_tag_q   <= sol.tag;
                cdb_value_q <= sol.value;
            end
            occ_q <= occ_q + 4'(issue_fire) - 4'(res_valid);
        end
    end

    assign bus.issue_ready    = |line_free;
    assign bus.issue_tag      = free_idx;
    assign bus.fu_run         = run_q;
    assign bus.fu_instruction = instr_q;
    assign bus.cdb_valid      = cdb_valid_q;
    assign bus.cdb_reg        = cdb_reg_q;
    assign bus.cdb_tag        = cdb_tag_q;
    assign bus.cdb_value      = cdb_value_q;
    assign bus.occupancy      = occ_q;
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: a vector table for the basic
// issue/wakeup/dispatch/result flow, then hand-written multi-cycle sequences.
module tb_reservation_station;
    import tomasulo_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    reservation_station_if bus ();
    reservation_station #(.ENTRIES(8)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    int total = 0;
    int passed = 0;

    localparam logic [42:0] BUB = {3'd0, 4'hF, 36'd0};

    typedef struct {
        string        name;
        logic         iv;
        logic [3:0]   op;
        logic [3:0]   dest;
        logic [15:0]  vj, vk;
        logic         qjb;
        logic [2:0]   qj;
        logic         qkb;
        logic [2:0]   qk;
        logic         req;
        logic         done;
        logic [22:0]  sol;
        logic         e_ready;
        logic [2:0]   e_tag;
        logic [42:0]  e_instr;
        logic         e_cv;
        logic [3:0]   e_creg;
        logic [2:0]   e_ctag;
        logic [15:0]  e_cval;
        logic [3:0]   e_occ;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [42:0] instr(input int tag, input logic [3:0] op, input int dest,
                                          input int vj, input int vk);
        return {3'(tag), op, 4'(dest), 16'(vj), 16'(vk)};
    endfunction

    function automatic logic [22:0] sol(input int dest, input int tag, input int val);
        return {4'(dest), 3'(tag), 16'(val)};
    endfunction

    function automatic vec_t mk(input string name, input int iv, input logic [3:0] op,
                                input int dest, input int vj, input int vk, input int qjb,
                                input int qj, input int qkb, input int qk, input int req,
                                input int done, input logic [22:0] sl, input int e_ready,
                                input int e_tag, input logic [42:0] e_instr, input int e_cv,
                                input int e_creg, input int e_ctag, input int e_cval,
                                input int e_occ);
        vec_t v;
        v.name = name; v.iv = 1'(iv); v.op = op; v.dest = 4'(dest);
        v.vj = 16'(vj); v.vk = 16'(vk); v.qjb = 1'(qjb); v.qj = 3'(qj);
        v.qkb = 1'(qkb); v.qk = 3'(qk); v.req = 1'(req); v.done = 1'(done); v.sol = sl;
        v.e_ready = 1'(e_ready); v.e_tag = 3'(e_tag); v.e_instr = e_instr;
        v.e_cv = 1'(e_cv); v.e_creg = 4'(e_creg); v.e_ctag = 3'(e_ctag);
        v.e_cval = 16'(e_cval); v.e_occ = 4'(e_occ);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0; bus.issue_op = 4'd0; bus.issue_dest = 4'd0;
        bus.issue_vj = 16'd0; bus.issue_vk = 16'd0;
        bus.issue_qj_busy = 1'b0; bus.issue_qk_busy = 1'b0;
        bus.issue_qj = 3'd0; bus.issue_qk = 3'd0;
        bus.fu_request = 1'b0; bus.fu_done = 1'b0; bus.fu_solution = 23'd0;
    endtask

    task automatic issue(input logic [3:0] op, input int dest, input int vj, input int vk,
                         input int qjb, input int qj, input int qkb, input int qk);
        bus.issue_valid = 1'b1; bus.issue_op = op; bus.issue_dest = 4'(dest);
        bus.issue_vj = 16'(vj); bus.issue_vk = 16'(vk);
        bus.issue_qj_busy = 1'(qjb); bus.issue_qj = 3'(qj);
        bus.issue_qk_busy = 1'(qkb); bus.issue_qk = 3'(qk);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0] = mk("v0_issue_add", 1, OP_ADD, 5, 3, 4, 0, 0, 0, 0, 1, 0, 23'd0,
                     1, 1, BUB, 0, 0, 0, 0, 1);
        vecs[1] = mk("v1_issue_mul_wait", 1, OP_MUL, 6, 'hdead, 2, 1, 0, 0, 0, 1, 0, 23'd0,
                     1, 2, instr(0, OP_ADD, 5, 3, 4), 0, 0, 0, 0, 2);
        vecs[2] = mk("v2_result_wakeup", 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 1, sol(5, 0, 7),
                     1, 0, BUB, 1, 5, 0, 7, 1);
        vecs[3] = mk("v3_dispatch_woken", 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 0, 23'd0,
                     1, 0, instr(1, OP_MUL, 6, 7, 2), 0, 5, 0, 7, 1);
        vecs[4] = mk("v4_result_line1", 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 1, sol(6, 1, 14),
                     1, 0, BUB, 1, 6, 1, 14, 0);
        vecs[5] = mk("v5_stale_done", 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 1, sol(3, 1, 99),
                     1, 0, BUB, 0, 6, 1, 14, 0);

        idle();
        #12;
        check("rst_issue_ready", 64'(bus.issue_ready), 64'(1));
        check("rst_issue_tag", 64'(bus.issue_tag), 64'(0));
        check("rst_fu_instr", 64'(bus.fu_instruction), 64'(BUB));
        check("rst_fu_run", 64'(bus.fu_run), 64'(0));
        check("rst_cdb_valid", 64'(bus.cdb_valid), 64'(0));
        check("rst_occupancy", 64'(bus.occupancy), 64'(0));
        reset_n = 1'b1;
        tick();
        check("run_after_reset", 64'(bus.fu_run), 64'(1));

        for (int i = 0; i < 6; i++) begin
            bus.issue_valid = vecs[i].iv; bus.issue_op = vecs[i].op;
            bus.issue_dest = vecs[i].dest; bus.issue_vj = vecs[i].vj; bus.issue_vk = vecs[i].vk;
            bus.issue_qj_busy = vecs[i].qjb; bus.issue_qj = vecs[i].qj;
            bus.issue_qk_busy = vecs[i].qkb; bus.issue_qk = vecs[i].qk;
            bus.fu_request = vecs[i].req; bus.fu_done = vecs[i].done;
            bus.fu_solution = vecs[i].sol;
            tick();
            check({vecs[i].name, "_ready"}, 64'(bus.issue_ready), 64'(vecs[i].e_ready));
            check({vecs[i].name, "_tag"}, 64'(bus.issue_tag), 64'(vecs[i].e_tag));
            check({vecs[i].name, "_instr"}, 64'(bus.fu_instruction), 64'(vecs[i].e_instr));
            check({vecs[i].name, "_cdb_valid"}, 64'(bus.cdb_valid), 64'(vecs[i].e_cv));
            check({vecs[i].name, "_cdb_reg"}, 64'(bus.cdb_reg), 64'(vecs[i].e_creg));
            check({vecs[i].name, "_cdb_tag"}, 64'(bus.cdb_tag), 64'(vecs[i].e_ctag));
            check({vecs[i].name, "_cdb_value"}, 64'(bus.cdb_value), 64'(vecs[i].e_cval));
            check({vecs[i].name, "_occ"}, 64'(bus.occupancy), 64'(vecs[i].e_occ));
        end

        // Fill all eight lines while the unit refuses work.
        idle();
        for (int i = 0; i < 8; i++) begin
            issue(OP_ADD, i, i, 1, 0, 0, 0, 0);
            tick();
        end
        check("full_occ", 64'(bus.occupancy), 64'(8));
        check("full_ready", 64'(bus.issue_ready), 64'(0));
        check("full_no_request_bubble", 64'(bus.fu_instruction), 64'(BUB));
        issue(OP_SUB, 9, 9, 9, 0, 0, 0, 0);
        tick();
        check("ninth_ignored_occ", 64'(bus.occupancy), 64'(8));
        check("ninth_ignored_ready", 64'(bus.issue_ready), 64'(0));
        idle();
        bus.fu_request = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("order_dispatch_%0d", k), 64'(bus.fu_instruction),
                  64'(instr(k, OP_ADD, k, k, 1)));
        end
        idle();
        bus.fu_done = 1'b1; bus.fu_solution = sol(0, 0, 1);
        check("free_ready_not_early", 64'(bus.issue_ready), 64'(0));
        tick();
        check("free_ready_next", 64'(bus.issue_ready), 64'(1));
        check("free_tag", 64'(bus.issue_tag), 64'(0));
        check("free_occ", 64'(bus.occupancy), 64'(7));
        check("free_cdb_value", 64'(bus.cdb_value), 64'(1));
        idle();
        issue(OP_DIV, 10, 1, 1, 0, 0, 0, 0);
        bus.fu_done = 1'b1; bus.fu_solution = sol(1, 1, 2);
        tick();
        check("issue_and_free_occ", 64'(bus.occupancy), 64'(7));
        check("issue_and_free_tag", 64'(bus.issue_tag), 64'(1));

        // Clean slate for the bypass case.
        idle();
        reset_n = 1'b0; #2; reset_n = 1'b1;
        bus.fu_request = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(OP_ADD, i, i + 1, 0, 0, 0, 0, 0);
            tick();
        end
        idle();
        bus.fu_request = 1'b1;
        tick();
        check("bypass_pre_dispatch_l2", 64'(bus.fu_instruction), 64'(instr(2, OP_ADD, 2, 3, 0)));
        idle();
        issue(OP_ADD, 3, 1, 0, 0, 0, 1, 2);
        bus.fu_done = 1'b1; bus.fu_solution = sol(2, 2, 9);
        tick();
        check("bypass_issue_tag", 64'(bus.issue_tag), 64'(2));
        check("bypass_occ", 64'(bus.occupancy), 64'(3));
        check("bypass_cdb_value", 64'(bus.cdb_value), 64'(9));
        idle();
        bus.fu_request = 1'b1;
        tick();
        check("bypass_dispatch", 64'(bus.fu_instruction), 64'(instr(3, OP_ADD, 3, 1, 9)));

        // Lines 0 and 3 EXEC; add a WAIT line, then reset mid-operation.
        idle();
        issue(OP_SUB, 4, 0, 5, 1, 0, 0, 0);
        tick();
        check("mid_wait_occ", 64'(bus.occupancy), 64'(4));
        idle();
        bus.fu_done = 1'b1; bus.fu_solution = sol(1, 1, 11);
        tick();
        check("mid_cdb_before_reset", 64'(bus.cdb_valid), 64'(1));
        idle();
        reset_n = 1'b0;
        #2;
        check("async_rst_instr", 64'(bus.fu_instruction), 64'(BUB));
        check("async_rst_run", 64'(bus.fu_run), 64'(0));
        check("async_rst_cdb", 64'({bus.cdb_valid, bus.cdb_reg, bus.cdb_tag, bus.cdb_value}),
              64'(0));
        check("async_rst_occ", 64'(bus.occupancy), 64'(0));
        check("async_rst_issue", 64'({bus.issue_ready, bus.issue_tag}), 64'(4'b1000));
        reset_n = 1'b1;
        tick();
        bus.fu_done = 1'b1; bus.fu_solution = sol(3, 0, 5);
        bus.fu_request = 1'b1;
        tick();
        check("stale_after_reset_cdb", 64'(bus.cdb_valid), 64'(0));
        check("stale_after_reset_occ", 64'(bus.occupancy), 64'(0));
        check("stale_after_reset_instr", 64'(bus.fu_instruction), 64'(BUB));
        check("stale_after_reset_run", 64'(bus.fu_run), 64'(1));
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
